// File: rtl/motoro3_deadtime_pkg.sv
// Shared definitions for the dead-time inserter: leg state encodings,
// decoded request type and the default dead-time length.
package motoro3_deadtime_pkg;

  localparam int DT_CYCLES_DEF = 20;
  localparam int DT_W_DEF      = 8;

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_HI   = 2'd1,
    LEG_LO   = 2'd2,
    LEG_DEAD = 2'd3
  } leg_state_t;

  typedef enum logic [1:0] {
    WANT_OFF = 2'd0,
    WANT_HI  = 2'd1,
    WANT_LO  = 2'd2
  } want_t;

  // H+L together is treated as "off"; the caller flags it separately.
  function automatic want_t decode_want(input logic req_h, input logic req_l);
    if (req_h && !req_l) return WANT_HI;
    if (req_l && !req_h) return WANT_LO;
    return WANT_OFF;
  endfunction

endpackage

// File: rtl/motoro3_deadtime_if.sv
// Gate-request / gate-output bundle of the dead-time inserter.
//   master: gate generator side (drives raw requests, fault_in, clrFault)
//   slave : dead-time inserter (drives protected gates, fault, shootErr)
interface motoro3_deadtime_if;
  logic aH_i, aL_i, bH_i, bL_i, cH_i, cL_i;
  logic fault_in;
  logic clrFault;
  logic aH, aL, bH, bL, cH, cL;
  logic fault;
  logic shootErr;

  modport master (
    output aH_i, aL_i, bH_i, bL_i, cH_i, cL_i, fault_in, clrFault,
    input  aH, aL, bH, bL, cH, cL, fault, shootErr
  );

  modport slave (
    input  aH_i, aL_i, bH_i, bL_i, cH_i, cL_i, fault_in, clrFault,
    output aH, aL, bH, bL, cH, cL, fault, shootErr
  );
endinterface

// File: rtl/motoro3_deadtime_leg.sv
// One half-bridge leg: request decode, leg FSM with dead-time counter,
// registered gate outputs.
//   clk, nRst      : clock, async active-low reset
//   req_h, req_l   : registered raw requests for this leg
//   fault          : blank request (latched fault or synchronized fault_in)
//   gate_h, gate_l : protected gate outputs (registered)
//   shoot          : combinational flag, H and L requested together
//
// state | meaning
// OFF   | both gates off, counter idle, waiting for a request
// HI    | high-side gate on
// LO    | low-side gate on
// DEAD  | both gates off, counter running, requests ignored
module motoro3_deadtime_leg
  import motoro3_deadtime_pkg::*;
#(
  parameter int DT_CYCLES = DT_CYCLES_DEF,
  parameter int DT_W      = DT_W_DEF
) (
  input  logic clk,
  input  logic nRst,
  input  logic req_h,
  input  logic req_l,
  input  logic fault,
  output logic gate_h,
  output logic gate_l,
  output logic shoot
);

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DT_CYCLES - 1);

  leg_state_t      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  want_t           want;

  assign want  = decode_want(req_h, req_l);
  assign shoot = req_h & req_l;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LEG_OFF: begin
        cnt_d = '0;
        if (!fault) begin
          if (want == WANT_HI)      state_d = LEG_HI;
          else if (want == WANT_LO) state_d = LEG_LO;
        end
      end
      LEG_HI: begin
        if (fault || want != WANT_HI) begin
          state_d = LEG_DEAD;
          cnt_d   = DT_LOAD;
        end
      end
      LEG_LO: begin
        if (fault || want != WANT_LO) begin
          state_d = LEG_DEAD;
          cnt_d   = DT_LOAD;
        end
      end
      LEG_DEAD: begin
        // The terminal-count cycle also acts as the OFF decision, so the
        // both-off gap is exactly DT_CYCLES rather than DT_CYCLES+1.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DT_W'(1);
        end else if (fault || want == WANT_OFF) begin
          state_d = LEG_OFF;
        end else if (want == WANT_HI) begin
          state_d = LEG_HI;
        end else begin
          state_d = LEG_LO;
        end
      end
      default: begin
        state_d = LEG_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= LEG_OFF;
      cnt_q   <= '0;
      gate_h  <= 1'b0;
      gate_l  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_h  <= (state_d == LEG_HI);
      gate_l  <= (state_d == LEG_LO);
    end
  end

endmodule

// File: rtl/motoro3_deadtime.sv
// Dead-time inserter and shoot-through guard for a 3-phase bridge.
//   clk, nRst : 10 MHz clock, async active-low reset
//   bus       : slave side of motoro3_deadtime_if (raw requests, fault_in,
//               clrFault in; protected gates, fault, shootErr out)
// Holds the request register stage, the fault_in synchronizer and the
// fault / shootErr latches; the three legs are identical instances.
module motoro3_deadtime
  import motoro3_deadtime_pkg::*;
#(
  parameter int DT_CYCLES = DT_CYCLES_DEF,
  parameter int DT_W      = DT_W_DEF
) (
  input logic                  clk,
  input logic                  nRst,
  motoro3_deadtime_if.slave    bus
);

  logic [2:0] req_h_q, req_l_q;
  logic [2:0] gate_h, gate_l, shoot;
  logic       fault_s1, fault_s;
  logic       fault_q, shoot_q;
  logic       fault_leg;

  // Including the synchronized input blanks the gates on the same edge the
  // latch sets, and keeps legs off for the cycle in which the latch clears.
  assign fault_leg = fault_q | fault_s;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      req_h_q  <= '0;
      req_l_q  <= '0;
      fault_s1 <= 1'b0;
      fault_s  <= 1'b0;
      fault_q  <= 1'b0;
      shoot_q  <= 1'b0;
    end else begin
      req_h_q  <= {bus.cH_i, bus.bH_i, bus.aH_i};
      req_l_q  <= {bus.cL_i, bus.bL_i, bus.aL_i};
      fault_s1 <= bus.fault_in;
      fault_s  <= fault_s1;
      if (fault_s)           fault_q <= 1'b1;
      else if (bus.clrFault) fault_q <= 1'b0;
      if (|shoot)            shoot_q <= 1'b1;
      else if (bus.clrFault) shoot_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_leg
    motoro3_deadtime_leg #(
      .DT_CYCLES (DT_CYCLES),
      .DT_W      (DT_W)
    ) u_leg (
      .clk    (clk),
      .nRst   (nRst),
      .req_h  (req_h_q[g]),
      .req_l  (req_l_q[g]),
      .fault  (fault_leg),
      .gate_h (gate_h[g]),
      .gate_l (gate_l[g]),
      .shoot  (shoot[g])
    );
  end

  assign bus.aH       = gate_h[0];
  assign bus.aL       = gate_l[0];
  assign bus.bH       = gate_h[1];
  assign bus.bL       = gate_l[1];
  assign bus.cH       = gate_h[2];
  assign bus.cL       = gate_l[2];
  assign bus.fault    = fault_q;
  assign bus.shootErr = shoot_q;

endmodule

// File: tb/tb_motoro3_deadtime.sv
module tb_motoro3_deadtime;

  logic clk;
  logic nRst;
  int   checks;
  int   errors;

  motoro3_deadtime_if bus20 ();
  motoro3_deadtime_if bus1 ();
  motoro3_deadtime_if bus255 ();

  motoro3_deadtime #(.DT_CYCLES(20), .DT_W(8)) u_dut (
    .clk (clk), .nRst (nRst), .bus (bus20)
  );
  motoro3_deadtime #(.DT_CYCLES(1), .DT_W(8)) u_dut1 (
    .clk (clk), .nRst (nRst), .bus (bus1)
  );
  motoro3_deadtime #(.DT_CYCLES(255), .DT_W(8)) u_dut255 (
    .clk (clk), .nRst (nRst), .bus (bus255)
  );

  // The DT=1 and DT=255 copies see the same stimulus as the main DUT.
  assign bus1.aH_i = bus20.aH_i;   assign bus255.aH_i = bus20.aH_i;
  assign bus1.aL_i = bus20.aL_i;   assign bus255.aL_i = bus20.aL_i;
  assign bus1.bH_i = bus20.bH_i;   assign bus255.bH_i = bus20.bH_i;
  assign bus1.bL_i = bus20.bL_i;   assign bus255.bL_i = bus20.bL_i;
  assign bus1.cH_i = bus20.cH_i;   assign bus255.cH_i = bus20.cH_i;
  assign bus1.cL_i = bus20.cL_i;   assign bus255.cL_i = bus20.cL_i;
  assign bus1.fault_in = bus20.fault_in;  assign bus255.fault_in = bus20.fault_in;
  assign bus1.clrFault = bus20.clrFault;  assign bus255.clrFault = bus20.clrFault;

  logic [2:0] mon_h [3];
  logic [2:0] mon_l [3];
  assign mon_h[0] = {bus20.cH, bus20.bH, bus20.aH};
  assign mon_l[0] = {bus20.cL, bus20.bL, bus20.aL};
  assign mon_h[1] = {bus1.cH, bus1.bH, bus1.aH};
  assign mon_l[1] = {bus1.cL, bus1.bL, bus1.aL};
  assign mon_h[2] = {bus255.cH, bus255.bH, bus255.aH};
  assign mon_l[2] = {bus255.cL, bus255.bL, bus255.aL};

  int dt_of [3] = '{20, 1, 255};
  int last_side [3][3];
  int off_cnt [3][3];

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Per-cycle guard on every DUT and leg: no H&L overlap, and a conducting
  // side may only hand over to the other side after >= DT off cycles.
  task automatic mon_check();
    for (int d = 0; d < 3; d++) begin
      for (int g = 0; g < 3; g++) begin
        if (!nRst) begin
          last_side[d][g] = 0;
          off_cnt[d][g]   = 0;
        end else begin
          checks++;
          if (mon_h[d][g] === 1'b1 && mon_l[d][g] === 1'b1) begin
            errors++;
            $display("FAIL overlap dut%0d leg%0d: H=1 L=1 required not both", d, g);
          end
          if (mon_h[d][g] === 1'b1) begin
            if (last_side[d][g] == 2 && off_cnt[d][g] < dt_of[d]) begin
              errors++;
              $display("FAIL gap dut%0d leg%0d L->H: off %0d cycles required >= %0d",
                       d, g, off_cnt[d][g], dt_of[d]);
            end
            last_side[d][g] = 1;
            off_cnt[d][g]   = 0;
          end else if (mon_l[d][g] === 1'b1) begin
            if (last_side[d][g] == 1 && off_cnt[d][g] < dt_of[d]) begin
              errors++;
              $display("FAIL gap dut%0d leg%0d H->L: off %0d cycles required >= %0d",
                       d, g, off_cnt[d][g], dt_of[d]);
            end
            last_side[d][g] = 2;
            off_cnt[d][g]   = 0;
          end else if (off_cnt[d][g] < 1000) begin
            off_cnt[d][g]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic all_req_off();
    bus20.aH_i = 0; bus20.aL_i = 0; bus20.bH_i = 0;
    bus20.bL_i = 0; bus20.cH_i = 0; bus20.cL_i = 0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    nRst = 1'b0;
    all_req_off();
    bus20.fault_in = 0;
    bus20.clrFault = 0;
    #120;
    outs = {bus20.aH, bus20.aL, bus20.bH, bus20.bL, bus20.cH, bus20.cL,
            bus20.fault, bus20.shootErr};
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000", outs);
    end
    @(posedge clk); #1;
    nRst = 1'b1;
    bus20.aH_i = 1;
    tick();
    checks++;
    if (bus20.aH !== 1'b0) begin
      errors++; $display("FAIL reset_first_edge_aH: got %b required 0", bus20.aH);
    end
    tick();
    checks++;
    if (bus20.aH !== 1'b1) begin
      errors++; $display("FAIL reset_second_edge_aH: got %b required 1", bus20.aH);
    end
    ticks(3);
    nRst = 1'b0;
    #1;
    outs = {bus20.aH, bus20.aL, bus20.bH, bus20.bL, bus20.cH, bus20.cL,
            bus20.fault, bus20.shootErr};
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_mid_hi: got %b required 00000000", outs);
    end
    tick();
    nRst = 1'b1;
    tick();
    checks++;
    if (bus20.aH !== 1'b0) begin
      errors++; $display("FAIL rerelease_first_edge_aH: got %b required 0", bus20.aH);
    end
    tick();
    checks++;
    if (bus20.aH !== 1'b1) begin
      errors++; $display("FAIL rerelease_second_edge_aH: got %b required 1", bus20.aH);
    end
  endtask

  task automatic test_hi_to_lo();
    int n;
    bus20.aH_i = 0;
    bus20.aL_i = 1;
    tick();
    checks++;
    if (bus20.aH !== 1'b1) begin
      errors++; $display("FAIL hilo_capture_aH: got %b required 1", bus20.aH);
    end
    tick();
    checks++;
    if ({bus20.aH, bus20.aL} !== 2'b00) begin
      errors++; $display("FAIL hilo_fall: got aH,aL=%b required 00", {bus20.aH, bus20.aL});
    end
    n = 1;
    while (bus20.aL !== 1'b1 && n < 300) begin
      tick();
      if (bus20.aL !== 1'b1) n++;
    end
    checks++;
    if (n != 20) begin
      errors++; $display("FAIL hilo_dead_cycles: got %0d required 20", n);
    end
    checks++;
    if ({bus20.aH, bus20.aL} !== 2'b01) begin
      errors++; $display("FAIL hilo_final: got aH,aL=%b required 01", {bus20.aH, bus20.aL});
    end
  endtask

  task automatic test_reentry();
    int n;
    bus20.bH_i = 1;
    ticks(3);
    checks++;
    if (bus20.bH !== 1'b1) begin
      errors++; $display("FAIL reentry_on: got %b required 1", bus20.bH);
    end
    bus20.bH_i = 0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus20.bH !== 1'b1) n++;
    end
    bus20.bH_i = 1;
    for (int i = 0; i < 300 && bus20.bH !== 1'b1; i++) begin
      tick();
      if (bus20.bH !== 1'b1) n++;
    end
    checks++;
    if (n != 20) begin
      errors++; $display("FAIL reentry_off_cycles: got %0d required 20", n);
    end
    bus20.bH_i = 0;
    ticks(25);
  endtask

  task automatic test_shoot();
    bus20.cH_i = 1; bus20.cL_i = 1;
    tick();
    checks++;
    if (bus20.shootErr !== 1'b0) begin
      errors++; $display("FAIL shoot_capture_edge: got %b required 0", bus20.shootErr);
    end
    tick();
    checks++;
    if ({bus20.cH, bus20.cL, bus20.shootErr} !== 3'b001) begin
      errors++; $display("FAIL shoot_set: got cH,cL,shootErr=%b required 001",
                         {bus20.cH, bus20.cL, bus20.shootErr});
    end
    bus20.cH_i = 0; bus20.cL_i = 0;
    ticks(3);
    checks++;
    if (bus20.shootErr !== 1'b1) begin
      errors++; $display("FAIL shoot_sticky: got %b required 1", bus20.shootErr);
    end
    bus20.clrFault = 1;
    tick();
    bus20.clrFault = 0;
    checks++;
    if (bus20.shootErr !== 1'b0) begin
      errors++; $display("FAIL shoot_clear: got %b required 0", bus20.shootErr);
    end
    bus20.cH_i = 1; bus20.cL_i = 1;
    tick();
    bus20.clrFault = 1;
    tick();
    bus20.clrFault = 0;
    checks++;
    if (bus20.shootErr !== 1'b1) begin
      errors++; $display("FAIL shoot_vs_clear: got %b required 1", bus20.shootErr);
    end
    bus20.cH_i = 0; bus20.cL_i = 0;
    tick();
    bus20.clrFault = 1;
    tick();
    bus20.clrFault = 0;
    checks++;
    if (bus20.shootErr !== 1'b0) begin
      errors++; $display("FAIL shoot_clear2: got %b required 0", bus20.shootErr);
    end
  endtask

  task automatic test_fault();
    all_req_off();
    ticks(30);
    bus20.aH_i = 1; bus20.bL_i = 1;
    ticks(3);
    checks++;
    if ({bus20.aH, bus20.bL} !== 2'b11) begin
      errors++; $display("FAIL fault_pre_gates: got aH,bL=%b required 11", {bus20.aH, bus20.bL});
    end
    bus20.fault_in = 1;
    ticks(2);
    checks++;
    if ({bus20.aH, bus20.bL, bus20.fault} !== 3'b110) begin
      errors++; $display("FAIL fault_sync_delay: got aH,bL,fault=%b required 110",
                         {bus20.aH, bus20.bL, bus20.fault});
    end
    tick();
    checks++;
    if ({bus20.aH, bus20.aL, bus20.bH, bus20.bL, bus20.cH, bus20.cL, bus20.fault} !== 7'b0000001) begin
      errors++; $display("FAIL fault_blank: got gates,fault=%b required 0000001",
                         {bus20.aH, bus20.aL, bus20.bH, bus20.bL, bus20.cH, bus20.cL, bus20.fault});
    end
    bus20.clrFault = 1;
    tick();
    bus20.clrFault = 0;
    checks++;
    if (bus20.fault !== 1'b1) begin
      errors++; $display("FAIL fault_clear_blocked: got %b required 1", bus20.fault);
    end
    bus20.fault_in = 0;
    ticks(30);
    checks++;
    if ({bus20.fault, bus20.aH, bus20.bL} !== 3'b100) begin
      errors++; $display("FAIL fault_held: got fault,aH,bL=%b required 100",
                         {bus20.fault, bus20.aH, bus20.bL});
    end
    bus20.clrFault = 1;
    tick();
    bus20.clrFault = 0;
    checks++;
    if ({bus20.fault, bus20.aH, bus20.bL} !== 3'b000) begin
      errors++; $display("FAIL fault_clear_edge: got fault,aH,bL=%b required 000",
                         {bus20.fault, bus20.aH, bus20.bL});
    end
    tick();
    checks++;
    if ({bus20.aH, bus20.bL} !== 2'b11) begin
      errors++; $display("FAIL fault_resume: got aH,bL=%b required 11", {bus20.aH, bus20.bL});
    end
  endtask

  task automatic set_leg(input int g, input logic [1:0] r);
    case (g)
      0: begin bus20.aH_i = r[1]; bus20.aL_i = r[0]; end
      1: begin bus20.bH_i = r[1]; bus20.bL_i = r[0]; end
      default: begin bus20.cH_i = r[1]; bus20.cL_i = r[0]; end
    endcase
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int i = 0; i < 4000; i++) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 5) == 0) begin
          r = 2'($urandom_range(0, 3));
          set_leg(g, r);
        end
      end
      tick();
    end
    all_req_off();
    ticks(300);
    checks++;
    if ({bus20.aH, bus20.aL, bus20.bH, bus20.bL, bus20.cH, bus20.cL} !== 6'b000000) begin
      errors++; $display("FAIL random_settle: got gates=%b required 000000",
                         {bus20.aH, bus20.aL, bus20.bH, bus20.bL, bus20.cH, bus20.cL});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hi_to_lo();
    test_reentry();
    test_shoot();
    test_fault();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
